// File: rtl/kernel_bc_ctrl_pkg.sv
// Shared definitions for the kernel_bc start-FIFO controllers.
package kernel_bc_ctrl_pkg;

  // ST_START means a start is being offered downstream and not yet accepted.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_START = 1'b1
  } state_t;

endpackage

// File: rtl/kernel_bc_start_token_consumer_if.sv
// Start-FIFO read port plus the downstream ap_start/ap_ready/ap_done handshake.
interface kernel_bc_start_token_consumer_if #(
  parameter int DATA_WIDTH = 1
);
  // fifo_read pops the head token in the same cycle fifo_empty_n is high; ap_start is
  // held until the cycle ap_ready is seen high, and that edge is the acceptance.
  logic                  fifo_empty_n;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_read;
  logic                  fifo_read_ce;
  logic                  ap_start;
  logic                  ap_ready;
  logic                  ap_done;
  logic [DATA_WIDTH-1:0] start_tag;

  modport master (
    input  fifo_empty_n, fifo_dout, ap_ready, ap_done,
    output fifo_read, fifo_read_ce, ap_start, start_tag
  );

  modport slave (
    output fifo_empty_n, fifo_dout, ap_ready, ap_done,
    input  fifo_read, fifo_read_ce, ap_start, start_tag
  );
endinterface

// File: rtl/kernel_bc_start_token_consumer.sv
// Pops start tokens, drives the downstream ap_start handshake, tracks outstanding
// invocations and completions.
module kernel_bc_start_token_consumer
  import kernel_bc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 1,
  parameter int MAX_INFLIGHT = 2,
  parameter int IF_WIDTH     = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  kernel_bc_start_token_consumer_if.master bus,
  output logic [IF_WIDTH-1:0]  inflight,
  output logic [CNT_WIDTH-1:0] done_count,
  output logic                 proto_err,
  output logic                 idle,
  output state_t               state
);

  localparam logic [IF_WIDTH-1:0] MAX_IF = IF_WIDTH'(MAX_INFLIGHT);

  logic                  start_q;
  logic [DATA_WIDTH-1:0] tag_q;
  logic                  accept;
  logic                  done_ok;
  logic                  pop;
  logic [IF_WIDTH-1:0]   occupied;
  logic [IF_WIDTH-1:0]   inflight_nx;

  // The slot limit is judged on the count after this edge, so a freeing ap_done
  // and the next pop can share a cycle.
  always_comb begin
    accept      = (state == ST_START) & bus.ap_ready;
    occupied    = inflight + IF_WIDTH'(accept);
    done_ok     = bus.ap_done & (occupied != '0);
    inflight_nx = occupied - IF_WIDTH'(done_ok);
    pop         = ~reset & enable & bus.fifo_empty_n & (inflight_nx < MAX_IF)
                  & ((state == ST_IDLE) | accept);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      tag_q      <= '0;
      inflight   <= '0;
      done_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      inflight <= inflight_nx;
      if (done_ok) done_count <= done_count + CNT_WIDTH'(1);
      if (bus.ap_done & ~done_ok) proto_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tag_q   <= bus.fifo_dout;
            state   <= ST_START;
            start_q <= 1'b1;
          end
        end
        ST_START: begin
          // Once offered, a start is never withdrawn before ap_ready.
          if (accept) begin
            if (pop) begin
              tag_q <= bus.fifo_dout;
            end else begin
              state   <= ST_IDLE;
              start_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_read    = pop;
  assign bus.fifo_read_ce = ~reset;
  assign bus.ap_start     = start_q;
  assign bus.start_tag    = tag_q;
  assign idle             = (state == ST_IDLE) & (inflight == '0) & ~bus.fifo_empty_n;

endmodule

// File: tb/tb_kernel_bc_start_token_consumer.sv
// Directed and randomized checks of the start-token consumer against a token-level model.
module tb_kernel_bc_start_token_consumer;
  import kernel_bc_ctrl_pkg::*;

  localparam int DW   = 1;
  localparam int MAXI = 2;
  localparam int IFW  = 2;
  localparam int CNTW = 4;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [IFW-1:0]  inflight;
  logic [CNTW-1:0] done_count;
  logic            proto_err;
  logic            idle;
  state_t          dut_state;

  kernel_bc_start_token_consumer_if #(.DATA_WIDTH(DW)) bus ();

  kernel_bc_start_token_consumer #(
    .DATA_WIDTH(DW), .MAX_INFLIGHT(MAXI), .IF_WIDTH(IFW), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .inflight(inflight), .done_count(done_count), .proto_err(proto_err),
    .idle(idle), .state(dut_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [DW-1:0] fq[$];

  // Reference model: one possibly-unaccepted start plus a count of accepted ones.
  bit              m_pending;
  logic [DW-1:0]   m_tag;
  int              m_inflight;
  logic [CNTW-1:0] m_done;
  bit              m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty_n = (fq.size() != 0);
    bus.fifo_dout    = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] v);
    fq.push_back(v);
    refresh();
  endtask

  task automatic model_reset();
    m_pending  = 0;
    m_tag      = '0;
    m_inflight = 0;
    m_done     = '0;
    m_err      = 0;
  endtask

  task automatic cycle();
    bit accepted, done_ok, exp_read, slot_free, pop;
    int occ, nxt;
    logic [DW-1:0] dout_s;
    accepted = 0; done_ok = 0; exp_read = 0; occ = 0; nxt = 0;
    @(negedge clk);
    if (reset) begin
      chk("read_in_reset", 32'(bus.fifo_read), 0);
      chk("ce_in_reset", 32'(bus.fifo_read_ce), 0);
    end else begin
      accepted  = m_pending && bus.ap_ready;
      occ       = m_inflight + int'(accepted);
      done_ok   = bus.ap_done && (occ > 0);
      nxt       = occ - int'(done_ok);
      slot_free = !m_pending || accepted;
      exp_read  = slot_free && enable && bus.fifo_empty_n && (nxt < MAXI);
      chk("fifo_read", 32'(bus.fifo_read), 32'(exp_read));
      chk("fifo_read_ce", 32'(bus.fifo_read_ce), 1);
      chk("ap_start", 32'(bus.ap_start), 32'(m_pending));
      chk("start_tag", 32'(bus.start_tag), 32'(m_tag));
      chk("inflight", 32'(inflight), 32'(m_inflight));
      chk("done_count", 32'(done_count), 32'(m_done));
      chk("proto_err", 32'(proto_err), 32'(m_err));
      chk("idle", 32'(idle), 32'(!m_pending && m_inflight == 0 && !bus.fifo_empty_n));
      chk("state", 32'(dut_state), m_pending ? 32'(ST_START) : 32'(ST_IDLE));
    end
    pop    = bus.fifo_read;
    dout_s = bus.fifo_dout;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (exp_read) begin
        m_pending = 1;
        m_tag     = dout_s;
      end else if (accepted) begin
        m_pending = 0;
      end
      m_inflight = nxt;
      if (done_ok) m_done = m_done + 1'b1;
      if (bus.ap_done && !done_ok) m_err = 1;
    end
    #1;
    if (pop && fq.size() > 0) begin
      void'(fq.pop_front());
      pops++;
    end
    refresh();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    chk("rst_ap_start", 32'(bus.ap_start), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_done_count", 32'(done_count), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    chk("rst_start_tag", 32'(bus.start_tag), 0);
    reset = 1'b0;
  endtask

  initial begin
    int p0;
    logic [CNTW-1:0] d0;
    reset = 1'b1; enable = 1'b0;
    bus.ap_ready = 1'b0; bus.ap_done = 1'b0;
    model_reset();
    refresh();
    @(posedge clk); #1;

    // One token, ap_ready tied high.
    do_reset();
    push(1'b1); enable = 1'b1; bus.ap_ready = 1'b1;
    p0 = pops;
    cycle();
    cycle();
    chk("t1_pops", 32'(pops - p0), 1);
    chk("t1_inflight", 32'(inflight), 1);
    chk("t1_ap_start_low", 32'(bus.ap_start), 0);

    // Three tokens against a two-slot limit.
    do_reset();
    repeat (3) push(DW'($urandom_range(0, 1)));
    enable = 1'b1; bus.ap_ready = 1'b1;
    p0 = pops;
    repeat (5) cycle();
    chk("t2_two_pops", 32'(pops - p0), 2);
    chk("t2_inflight_full", 32'(inflight), 2);
    bus.ap_done = 1'b1;
    cycle();
    bus.ap_done = 1'b0;
    chk("t2_pop_on_done", 32'(pops - p0), 3);
    cycle();
    bus.ap_done = 1'b1;
    repeat (2) cycle();
    bus.ap_done = 1'b0;
    chk("t2_drained", 32'(inflight), 0);
    chk("t2_done_count", 32'(done_count), 3);

    // Start held through ap_ready low with enable dropped.
    do_reset();
    push(DW'($urandom_range(0, 1)));
    enable = 1'b1; bus.ap_ready = 1'b0;
    cycle();
    enable = 1'b0;
    push(DW'($urandom_range(0, 1)));
    p0 = pops;
    repeat (5) begin
      cycle();
      chk("t3_ap_start_held", 32'(bus.ap_start), 1);
    end
    chk("t3_no_pop", 32'(pops - p0), 0);
    bus.ap_ready = 1'b1;
    cycle();
    chk("t3_inflight", 32'(inflight), 1);
    chk("t3_ap_start_low", 32'(bus.ap_start), 0);

    // ap_ready and ap_done together with one outstanding.
    enable = 1'b1; bus.ap_ready = 1'b0;
    cycle();
    d0 = done_count;
    bus.ap_ready = 1'b1; bus.ap_done = 1'b1;
    cycle();
    bus.ap_ready = 1'b0; bus.ap_done = 1'b0;
    chk("t4_inflight", 32'(inflight), 1);
    chk("t4_done_count", 32'(done_count), 32'(CNTW'(d0 + 1'b1)));

    // Spurious ap_done.
    do_reset();
    enable = 1'b0; bus.ap_done = 1'b1;
    cycle();
    bus.ap_done = 1'b0;
    chk("t5_proto_err", 32'(proto_err), 1);
    chk("t5_done_count", 32'(done_count), 0);
    repeat (3) cycle();
    chk("t5_sticky", 32'(proto_err), 1);
    do_reset();

    // Reset while a start is being offered.
    push(DW'($urandom_range(0, 1)));
    push(1'b1);
    enable = 1'b1; bus.ap_ready = 1'b1;
    cycle();
    cycle();
    chk("t6_ap_start_pre", 32'(bus.ap_start), 1);
    chk("t6_inflight_pre", 32'(inflight), 1);
    reset = 1'b1; bus.ap_ready = 1'b0;
    cycle();
    chk("t6_ap_start", 32'(bus.ap_start), 0);
    chk("t6_inflight", 32'(inflight), 0);
    chk("t6_start_tag", 32'(bus.start_tag), 0);
    chk("t6_idle", 32'(idle), 1);
    chk("t6_fifo_read", 32'(bus.fifo_read), 0);
    reset = 1'b0;

    // Randomized traffic; done_count wraps several times at this width.
    for (int i = 0; i < 800; i++) begin
      if (fq.size() < 4 && $urandom_range(0, 2) == 0) push(DW'($urandom_range(0, 1)));
      enable       = ($urandom_range(0, 9) != 0);
      bus.ap_ready = ($urandom_range(0, 2) != 0);
      bus.ap_done  = ($urandom_range(0, 3) == 0);
      cycle();
    end
    bus.ap_done = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
